// File: rtl/d_uncache_ctrl.sv
// Uncached data-access bridge: one CPU load/store at a time
// mapped onto AXI-style AR/R and AW/W/B channels.
module d_uncache_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [1:0]  cpu_size,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_addr_ok,
  output logic        cpu_data_ok,
  output logic [31:0] cpu_rdata,
  output logic [31:0] ar_addr,
  output logic [2:0]  ar_size,
  output logic        ar_valid,
  input  logic        ar_ready,
  input  logic [31:0] r_data,
  input  logic        r_valid,
  output logic        r_ready,
  output logic [31:0] aw_addr,
  output logic [2:0]  aw_size,
  output logic        aw_valid,
  input  logic        aw_ready,
  output logic [31:0] w_data,
  output logic [3:0]  w_strb,
  output logic        w_valid,
  input  logic        w_ready,
  input  logic        b_valid,
  output logic        b_ready
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  strb_q, strb_d;
  logic [31:0] rdata_q, rdata_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;

  logic        accept;
  logic [1:0]  size_n;
  logic [3:0]  strb_n;
  logic        aw_hs, w_hs;

  // size 3 is folded into word before it reaches the bus
  always_comb begin
    size_n = (cpu_size == 2'd3) ? 2'd2 : cpu_size;
    strb_n = 4'b1111;
    unique case (size_n)
      2'd0:    strb_n = 4'b0001 << cpu_addr[1:0];
      2'd1:    strb_n = cpu_addr[1] ? 4'b1100 : 4'b0011;
      default: strb_n = 4'b1111;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_q      <= 1'b0;
      size_q    <= 2'd0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      strb_q    <= 4'd0;
      rdata_q   <= 32'd0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_d;
      size_q    <= size_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      rdata_q   <= rdata_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  assign accept = (state_q == IDLE) && cpu_req && !rst;
  assign aw_hs  = aw_valid && aw_ready;
  assign w_hs   = w_valid && w_ready;

  always_comb begin
    state_d   = state_q;
    wr_d      = wr_q;
    size_d    = size_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    rdata_d   = rdata_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          wr_d      = cpu_wr;
          size_d    = size_n;
          addr_d    = cpu_addr;
          wdata_d   = cpu_wdata;
          strb_d    = strb_n;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = cpu_wr ? WR_REQ : RD_ADDR;
        end
      end
      RD_ADDR: begin
        if (ar_ready) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (r_valid) begin
          rdata_d = r_data;
          state_d = DONE;
        end
      end
      WR_REQ: begin
        // each channel retires on its own; leave once both have
        aw_done_d = aw_done_q || aw_hs;
        w_done_d  = w_done_q || w_hs;
        if (aw_done_d && w_done_d) state_d = WR_RESP;
      end
      WR_RESP: begin
        if (b_valid) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cpu_addr_ok = accept;
    cpu_data_ok = (state_q == DONE);
    cpu_rdata   = rdata_q;
    ar_addr     = addr_q;
    ar_size     = {1'b0, size_q};
    ar_valid    = (state_q == RD_ADDR);
    r_ready     = (state_q == RD_DATA);
    aw_addr     = addr_q;
    aw_size     = {1'b0, size_q};
    aw_valid    = (state_q == WR_REQ) && !aw_done_q;
    w_data      = wdata_q;
    w_strb      = strb_q;
    w_valid     = (state_q == WR_REQ) && !w_done_q && wr_q;
    b_ready     = (state_q == WR_RESP);
  end

endmodule

// File: tb/tb_d_uncache_ctrl.sv
// Directed bench for d_uncache_ctrl: response scoreboard on
// cpu_data_ok plus cycle-accurate channel checks.
module tb_d_uncache_ctrl;

  logic        clk;
  logic        rst;
  logic        cpu_req;
  logic        cpu_wr;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_addr_ok;
  logic        cpu_data_ok;
  logic [31:0] cpu_rdata;
  logic [31:0] ar_addr;
  logic [2:0]  ar_size;
  logic        ar_valid;
  logic        ar_ready;
  logic [31:0] r_data;
  logic        r_valid;
  logic        r_ready;
  logic [31:0] aw_addr;
  logic [2:0]  aw_size;
  logic        aw_valid;
  logic        aw_ready;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        w_valid;
  logic        w_ready;
  logic        b_valid;
  logic        b_ready;

  int          n_tests;
  int          n_fail;
  logic [31:0] exp_q[$];

  d_uncache_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_req     (cpu_req),
    .cpu_wr      (cpu_wr),
    .cpu_size    (cpu_size),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_addr_ok (cpu_addr_ok),
    .cpu_data_ok (cpu_data_ok),
    .cpu_rdata   (cpu_rdata),
    .ar_addr     (ar_addr),
    .ar_size     (ar_size),
    .ar_valid    (ar_valid),
    .ar_ready    (ar_ready),
    .r_data      (r_data),
    .r_valid     (r_valid),
    .r_ready     (r_ready),
    .aw_addr     (aw_addr),
    .aw_size     (aw_size),
    .aw_valid    (aw_valid),
    .aw_ready    (aw_ready),
    .w_data      (w_data),
    .w_strb      (w_strb),
    .w_valid     (w_valid),
    .w_ready     (w_ready),
    .b_valid     (b_valid),
    .b_ready     (b_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name,
                      input logic act,
                      input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // response monitor: every data_ok pulse must match the queue head
  always @(negedge clk) begin
    if (cpu_data_ok) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected data_ok: rdata %h, none expected",
                 cpu_rdata);
      end else begin
        chk("sb rdata", cpu_rdata, exp_q.pop_front());
      end
    end
  end

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    cpu_req   = 1'b0;
    cpu_wr    = 1'b0;
    cpu_size  = 2'd0;
    cpu_addr  = 32'd0;
    cpu_wdata = 32'd0;
    ar_ready  = 1'b0;
    r_data    = 32'd0;
    r_valid   = 1'b0;
    aw_ready  = 1'b0;
    w_ready   = 1'b0;
    b_valid   = 1'b0;
    rst       = 1'b1;
    #2;
    chk1("rst ar_valid", ar_valid, 1'b0);
    chk1("rst aw_valid", aw_valid, 1'b0);
    chk1("rst w_valid", w_valid, 1'b0);
    chk1("rst r_ready", r_ready, 1'b0);
    chk1("rst b_ready", b_ready, 1'b0);
    chk1("rst data_ok", cpu_data_ok, 1'b0);
    chk("rst rdata", cpu_rdata, 32'd0);
    chk("rst aw_addr", aw_addr, 32'd0);
    chk("rst w_strb", 32'(w_strb), 32'd0);
    tick();
    tick();
    rst = 1'b0;

    // load word, slave always ready
    ar_ready = 1'b1;
    r_valid  = 1'b1;
    r_data   = 32'h1234_5678;
    aw_ready = 1'b1;
    w_ready  = 1'b1;
    b_valid  = 1'b1;
    cpu_req  = 1'b1;
    cpu_wr   = 1'b0;
    cpu_size = 2'd2;
    cpu_addr = 32'h1FAF_0000;
    #1;
    chk1("ld c0 addr_ok", cpu_addr_ok, 1'b1);
    exp_q.push_back(32'h1234_5678);
    tick();
    cpu_req = 1'b0;
    chk1("ld c1 ar_valid", ar_valid, 1'b1);
    chk("ld c1 ar_addr", ar_addr, 32'h1FAF_0000);
    chk("ld c1 ar_size", 32'(ar_size), 32'd2);
    chk1("ld c1 r_ready", r_ready, 1'b0);
    chk1("ld c1 addr_ok", cpu_addr_ok, 1'b0);
    tick();
    chk1("ld c2 ar_valid", ar_valid, 1'b0);
    chk1("ld c2 r_ready", r_ready, 1'b1);
    chk1("ld c2 data_ok", cpu_data_ok, 1'b0);
    tick();
    chk1("ld c3 data_ok", cpu_data_ok, 1'b1);
    chk("ld c3 rdata", cpu_rdata, 32'h1234_5678);
    tick();
    chk1("ld c4 data_ok", cpu_data_ok, 1'b0);

    // store byte, aw_ready late, w_ready immediate
    aw_ready  = 1'b0;
    b_valid   = 1'b0;
    cpu_req   = 1'b1;
    cpu_wr    = 1'b1;
    cpu_size  = 2'd0;
    cpu_addr  = 32'h1FAF_F003;
    cpu_wdata = 32'hAB00_0000;
    #1;
    chk1("sb c0 addr_ok", cpu_addr_ok, 1'b1);
    exp_q.push_back(32'h1234_5678);
    tick();
    cpu_req = 1'b0;
    chk1("sb c1 aw_valid", aw_valid, 1'b1);
    chk1("sb c1 w_valid", w_valid, 1'b1);
    chk("sb c1 w_strb", 32'(w_strb), 32'h8);
    chk("sb c1 aw_size", 32'(aw_size), 32'd0);
    chk("sb c1 aw_addr", aw_addr, 32'h1FAF_F003);
    chk("sb c1 w_data", w_data, 32'hAB00_0000);
    tick();
    chk1("sb c2 w_valid", w_valid, 1'b0);
    chk1("sb c2 aw_valid", aw_valid, 1'b1);
    tick();
    chk1("sb c3 w_valid", w_valid, 1'b0);
    chk1("sb c3 aw_valid", aw_valid, 1'b1);
    aw_ready = 1'b1;
    tick();
    chk1("sb c4 aw_valid", aw_valid, 1'b0);
    chk1("sb c4 w_valid", w_valid, 1'b0);
    chk1("sb c4 b_ready", b_ready, 1'b1);
    chk1("sb c4 data_ok", cpu_data_ok, 1'b0);
    tick();
    chk1("sb c5 b_ready", b_ready, 1'b1);
    chk1("sb c5 data_ok", cpu_data_ok, 1'b0);
    b_valid = 1'b1;
    tick();
    chk1("sb c6 data_ok", cpu_data_ok, 1'b1);
    chk1("sb c6 b_ready", b_ready, 1'b0);
    tick();
    chk1("sb c7 data_ok", cpu_data_ok, 1'b0);

    // store half, upper lanes
    cpu_req   = 1'b1;
    cpu_size  = 2'd1;
    cpu_addr  = 32'h1FAF_0002;
    cpu_wdata = 32'hBEEF_0000;
    #1;
    exp_q.push_back(32'h1234_5678);
    tick();
    cpu_req = 1'b0;
    chk("sh c1 w_strb", 32'(w_strb), 32'hC);
    chk("sh c1 aw_size", 32'(aw_size), 32'd1);
    tick();
    tick();
    chk1("sh c3 data_ok", cpu_data_ok, 1'b1);
    tick();

    // size 3 store behaves as word
    cpu_req   = 1'b1;
    cpu_size  = 2'd3;
    cpu_addr  = 32'h1FAF_0001;
    cpu_wdata = 32'h0BAD_CAFE;
    #1;
    exp_q.push_back(32'h1234_5678);
    tick();
    cpu_req = 1'b0;
    chk("s3 c1 w_strb", 32'(w_strb), 32'hF);
    chk("s3 c1 aw_size", 32'(aw_size), 32'd2);
    chk("s3 c1 aw_addr", aw_addr, 32'h1FAF_0001);
    tick();
    tick();
    chk1("s3 c3 data_ok", cpu_data_ok, 1'b1);
    tick();

    // back-to-back loads, cpu_req held high
    b_valid  = 1'b0;
    r_data   = 32'h1111_1111;
    cpu_req  = 1'b1;
    cpu_wr   = 1'b0;
    cpu_size = 2'd2;
    cpu_addr = 32'h1FAF_0100;
    #1;
    chk1("bb c0 addr_ok", cpu_addr_ok, 1'b1);
    exp_q.push_back(32'h1111_1111);
    exp_q.push_back(32'h2222_2222);
    tick();
    cpu_addr = 32'h1FAF_0200;
    chk1("bb c1 addr_ok", cpu_addr_ok, 1'b0);
    chk("bb c1 ar_addr", ar_addr, 32'h1FAF_0100);
    tick();
    chk1("bb c2 addr_ok", cpu_addr_ok, 1'b0);
    tick();
    chk1("bb c3 addr_ok", cpu_addr_ok, 1'b0);
    chk1("bb c3 data_ok", cpu_data_ok, 1'b1);
    r_data = 32'h2222_2222;
    tick();
    chk1("bb c4 addr_ok", cpu_addr_ok, 1'b1);
    chk1("bb c4 data_ok", cpu_data_ok, 1'b0);
    tick();
    cpu_req = 1'b0;
    chk1("bb c5 ar_valid", ar_valid, 1'b1);
    chk("bb c5 ar_addr", ar_addr, 32'h1FAF_0200);
    tick();
    tick();
    chk1("bb c7 data_ok", cpu_data_ok, 1'b1);
    tick();
    chk1("bb c8 data_ok", cpu_data_ok, 1'b0);

    // reset while waiting for read data
    r_valid  = 1'b0;
    cpu_req  = 1'b1;
    cpu_addr = 32'h1FAF_0300;
    tick();
    cpu_req = 1'b0;
    tick();
    chk1("rr c2 r_ready", r_ready, 1'b1);
    r_valid = 1'b1;
    r_data  = 32'hDEAD_BEEF;
    #1;
    rst = 1'b1;
    #1;
    chk1("rr async r_ready", r_ready, 1'b0);
    chk1("rr async ar_valid", ar_valid, 1'b0);
    chk1("rr async data_ok", cpu_data_ok, 1'b0);
    chk("rr async rdata", cpu_rdata, 32'd0);
    chk("rr async ar_addr", ar_addr, 32'd0);
    tick();
    tick();
    rst      = 1'b0;
    r_data   = 32'hCAFE_F00D;
    cpu_req  = 1'b1;
    cpu_addr = 32'h1FAF_0400;
    #1;
    chk1("ra c0 addr_ok", cpu_addr_ok, 1'b1);
    exp_q.push_back(32'hCAFE_F00D);
    tick();
    cpu_req = 1'b0;
    chk("ra c1 ar_addr", ar_addr, 32'h1FAF_0400);
    tick();
    tick();
    chk1("ra c3 data_ok", cpu_data_ok, 1'b1);
    chk("ra c3 rdata", cpu_rdata, 32'hCAFE_F00D);
    tick();
    tick();
    tick();
    chk("sb leftover", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/d_uncache_ctrl.md
D_UNCACHE_CTRL -- requirements
Module: d_uncache_ctrl

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed below.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 cpu_req  in  1  uncached data request from the pipeline (physical address, no_dcache=1 path).
REQ-005 cpu_wr  in  1  1 = store, 0 = load.
REQ-006 cpu_size  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
REQ-007 cpu_addr  in  32  physical address.
REQ-008 cpu_wdata  in  32  store data, already lane-aligned.
REQ-009 cpu_addr_ok  out  1  request accepted this cycle.
REQ-010 cpu_data_ok  out  1  one-cycle pulse: load data valid or store complete.
REQ-011 cpu_rdata  out  32  load data, valid while cpu_data_ok=1.
REQ-012 ar_addr/ar_size  out  32/3  read address and size ({1'b0,size}); ar_valid out 1; ar_ready in 1.
REQ-013 r_data  in  32; r_valid in 1; r_ready out 1  read data channel.
REQ-014 aw_addr/aw_size  out  32/3; aw_valid out 1; aw_ready in 1  write address channel.
REQ-015 w_data  out  32; w_strb out 4; w_valid out 1; w_ready in 1  write data channel.
REQ-016 b_valid  in  1; b_ready out 1  write response channel.

Function
REQ-017 The FSM SHALL have states IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE; one transaction outstanding at a time.
REQ-018 cpu_addr_ok SHALL equal cpu_req while in IDLE and 0 in every other state (combinational).
REQ-019 On acceptance the block SHALL register wr, size, addr, wdata and computed strb; IDLE -> RD_ADDR (load) or WR_REQ (store).
REQ-020 Strobe: byte 4'b0001<<addr[1:0]; half addr[1]?4'b1100:4'b0011; word/size3 4'b1111; addr passed to bus unmodified.
REQ-021 RD_ADDR: ar_valid=1 with registered addr/size; on ar_valid&ar_ready -> RD_DATA.
REQ-022 RD_DATA: r_ready=1; on r_valid capture r_data into rdata register -> DONE.
REQ-023 WR_REQ: aw_valid and w_valid both rise on entry; each SHALL drop independently the cycle after its own handshake and never re-assert for the same transaction; when both handshakes done (same or different cycles) -> WR_RESP.
REQ-024 WR_RESP: b_ready=1; on b_valid -> DONE.
REQ-025 DONE: cpu_data_ok=1 for exactly one cycle, cpu_rdata = captured data (loads; stores hold last value); -> IDLE.
REQ-026 Latency with all slave ready/valid signals permanently 1: accept at cycle 0, data_ok at cycle 3 for loads and for stores.
REQ-027 Valid signals SHALL be held stable with stable payload until handshake (no retraction under back-pressure).
REQ-028 r_valid/b_valid arriving in states not expecting them SHALL be ignored; r_ready/b_ready are 0 outside RD_DATA/WR_RESP.
REQ-029 A new cpu_req while busy SHALL be stalled (addr_ok=0), never dropped or merged.

Reset
REQ-030 On rst=1, immediately and independent of clk: state IDLE, all valid/ready outputs 0, cpu_data_ok 0, cpu_rdata 0, registered addr/data/strb 0.
REQ-031 Reset mid-transaction SHALL abandon it without a cpu_data_ok pulse; first request after rst deassertion is accepted normally.

Verification
REQ-032 Load word 0x1FAF_0000, slave always ready, r_data 0x1234_5678 -> ar_valid cycle 1, r_ready cycle 2, data_ok=1 with rdata 0x1234_5678 at cycle 3 only.
REQ-033 Store byte addr 0x1FAF_F003 -> w_strb 4'b1000, aw_size 0; aw_ready delayed 3 cycles, w_ready immediate -> w_valid drops after 1 cycle, aw_valid held 3 cycles, data_ok one cycle after b_valid.
REQ-034 Store half addr 0x1FAF_0002 -> w_strb 4'b1100; size 3 store -> strb 4'b1111, aw_size 3'b010.
REQ-035 Back-to-back loads with cpu_req held high -> second addr_ok only in IDLE after DONE; exactly two data_ok pulses, order preserved.
REQ-036 Assert rst in RD_DATA with r_valid pending -> outputs zero immediately, no data_ok; following load completes correctly.
